// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the single-clock FIFO.
package fifo_pkg;

    typedef enum logic {FifoStd, FifoFwft} fifo_mode_e;

    // Pointer and level width: one extra bit so a full FIFO (level == depth) is representable.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Bundle of the write/read handshake, status and error signals of sync_fifo.
interface sync_fifo_if #(
    parameter int Width = 8,
    parameter int Depth = 4
);
    import fifo_pkg::*;

    localparam int Lw = fifo_ptr_w(Depth);

    // Handshake: a write is taken on a rising edge when i_wr_en & ~o_wr_full, a read
    // when i_rd_en & ~o_rd_empty; both flags are registered, never combinational.
    logic             i_flush;
    logic             i_wr_en;
    logic [Width-1:0] i_wr_data;
    logic             o_wr_full;
    logic             o_wr_almost_full;
    logic             i_rd_en;
    logic [Width-1:0] o_rd_data;
    logic             o_rd_empty;
    logic             o_rd_almost_empty;
    logic [Lw-1:0]    o_level;
    logic             o_overflow;
    logic             o_underflow;

    modport master (
        output i_flush, i_wr_en, i_wr_data, i_rd_en,
        input  o_wr_full, o_wr_almost_full, o_rd_data, o_rd_empty,
        input  o_rd_almost_empty, o_level, o_overflow, o_underflow
    );

    modport slave (
        input  i_flush, i_wr_en, i_wr_data, i_rd_en,
        output o_wr_full, o_wr_almost_full, o_rd_data, o_rd_empty,
        output o_rd_almost_empty, o_level, o_overflow, o_underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// Depth x Width storage: synchronous write port, asynchronous read port.
module fifo_ram #(
    parameter  int Width = 8,
    parameter  int Depth = 4,
    localparam int Aw    = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [Aw-1:0]    i_waddr,
    input  logic [Width-1:0] i_wdata,
    input  logic [Aw-1:0]    i_raddr,
    output logic [Width-1:0] o_rdata
);

    logic [Width-1:0] r_mem [Depth];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill level, almost flags, sticky errors, flush and optional FWFT read.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int Width          = 8,
    parameter int Depth          = 4,
    parameter int Fwft           = 0,
    parameter int AlmostFullThr  = Depth - 1,
    parameter int AlmostEmptyThr = 1
) (
    input logic        clk,
    input logic        rst_n,
    sync_fifo_if.slave bus
);

    localparam int         Pw   = fifo_ptr_w(Depth);
    localparam int         Aw   = Pw - 1;
    localparam fifo_mode_e Mode = (Fwft != 0) ? FifoFwft : FifoStd;

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: Depth must be a power of two >= 2");
    end
    if (AlmostFullThr < 1 || AlmostFullThr > Depth) begin : g_bad_afull
        $error("sync_fifo: AlmostFullThr out of range 1..Depth");
    end
    if (AlmostEmptyThr < 0 || AlmostEmptyThr > Depth - 1) begin : g_bad_aempty
        $error("sync_fifo: AlmostEmptyThr out of range 0..Depth-1");
    end

    logic [Pw-1:0]    r_wr_ptr, r_rd_ptr, r_level;
    logic             r_full, r_empty, r_afull, r_aempty;
    logic             r_overflow, r_underflow;
    logic             w_wr_acc, w_rd_acc;
    logic [Pw-1:0]    w_level_nxt;
    logic [Width-1:0] w_ram_rdata;

    // Acceptance looks only at registered flags, so a full FIFO drops a write even if read this cycle.
    assign w_wr_acc = bus.i_wr_en & ~r_full;
    assign w_rd_acc = bus.i_rd_en & ~r_empty;

    always_comb begin
        w_level_nxt = r_level;
        if (bus.i_flush)               w_level_nxt = '0;
        else if (w_wr_acc && !w_rd_acc) w_level_nxt = r_level + Pw'(1);
        else if (w_rd_acc && !w_wr_acc) w_level_nxt = r_level - Pw'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_level  <= w_level_nxt;
            r_full   <= (w_level_nxt == Pw'(Depth));
            r_empty  <= (w_level_nxt == '0);
            r_afull  <= (w_level_nxt >= Pw'(AlmostFullThr));
            r_aempty <= (w_level_nxt <= Pw'(AlmostEmptyThr));
            if (bus.i_flush) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                if (w_wr_acc)                   r_wr_ptr    <= r_wr_ptr + Pw'(1);
                if (w_rd_acc)                   r_rd_ptr    <= r_rd_ptr + Pw'(1);
                if (bus.i_wr_en && r_full)  r_overflow  <= 1'b1;
                if (bus.i_rd_en && r_empty) r_underflow <= 1'b1;
            end
        end
    end

    fifo_ram #(.Width(Width), .Depth(Depth)) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc & ~bus.i_flush),
        .i_waddr (r_wr_ptr[Aw-1:0]),
        .i_wdata (bus.i_wr_data),
        .i_raddr (r_rd_ptr[Aw-1:0]),
        .o_rdata (w_ram_rdata)
    );

    if (Mode == FifoStd) begin : g_std
        logic [Width-1:0] r_rd_data;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                       r_rd_data <= '0;
            else if (w_rd_acc && !bus.i_flush) r_rd_data <= w_ram_rdata;
        end
        assign bus.o_rd_data = r_rd_data;
    end else begin : g_fwft
        assign bus.o_rd_data = r_empty ? '0 : w_ram_rdata;
    end

    assign bus.o_wr_full         = r_full;
    assign bus.o_wr_almost_full  = r_afull;
    assign bus.o_rd_empty        = r_empty;
    assign bus.o_rd_almost_empty = r_aempty;
    assign bus.o_level           = r_level;
    assign bus.o_overflow        = r_overflow;
    assign bus.o_underflow       = r_underflow;

endmodule
